// File: rtl/slicel_cfg_pkg.sv
// Shared types and sizing helpers for the slice configuration loader.
package slicel_cfg_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Standard slice chain make-up; kept current by the slice owners.
  localparam int S_XX_BASE    = 16;
  localparam int NUM_LUTS     = 2;
  localparam int MODE_BITS    = 16;
  localparam int DEF_CFG_BITS = 2 * S_XX_BASE * NUM_LUTS + MODE_BITS;
  localparam int DEF_WORD_W   = 32;

  // Number of host words needed to cover the whole chain.
  function automatic int nwords(input int cfg_bits, input int word_w);
    return (cfg_bits + word_w - 1) / word_w;
  endfunction

  // Useful bits in the final word, in the range 1..word_w.
  function automatic int last_bits(input int cfg_bits, input int word_w);
    return cfg_bits - (nwords(cfg_bits, word_w) - 1) * word_w;
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// Parallel-load, serial-out shift register with a bit down-counter.
// The LSB is presented first; `last` flags the final bit of the loaded length.
module cfg_piso
  import slicel_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = $clog2(WORD_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LEN_W-1:0]  len,
  input  logic [WORD_W-1:0] din,
  input  logic              shift,
  output logic              ser_bit,
  output logic              last
);

  logic [WORD_W-1:0] shreg_r;
  logic [LEN_W-1:0]  cnt_r;

  // Capture a new word or move one bit towards the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_r <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      shreg_r <= din;
      cnt_r   <= len;
    end else if (shift) begin
      shreg_r <= {1'b0, shreg_r[WORD_W-1:1]};
      cnt_r   <= cnt_r - LEN_W'(1);
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  assign ser_bit = shreg_r[0];
  assign last    = (cnt_r == LEN_W'(1));

endmodule

// File: rtl/slicel_config_loader.sv
// Loads a slice configuration chain from a word-wide valid/ready stream,
// LSB-first, one bit per cycle, then pulses the chain's set strobe.
module slicel_config_loader
  import slicel_cfg_pkg::*;
#(
  parameter int CFG_BITS = DEF_CFG_BITS,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              chain_shift_en,
  output logic              chain_shift_bit,
  output logic              chain_set,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS    = nwords(CFG_BITS, WORD_W);
  localparam int LAST_BITS = last_bits(CFG_BITS, WORD_W);
  localparam int LEN_W     = $clog2(WORD_W) + 1;
  localparam int WCW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(WORD_W);
  localparam logic [LEN_W-1:0] LAST_LEN   = LEN_W'(LAST_BITS);
  localparam logic [WCW-1:0]   FINAL_WORD = WCW'(NWORDS - 1);

  state_t           state_r;
  state_t           state_s;
  logic [WCW-1:0]   word_cnt_r;
  logic [WCW-1:0]   word_cnt_s;
  logic             load_s;
  logic             shift_s;
  logic [LEN_W-1:0] len_s;
  logic             bit_s;
  logic             last_s;
  logic             final_word_s;

  assign final_word_s = (word_cnt_r == FINAL_WORD);

  cfg_piso #(
    .WORD_W (WORD_W),
    .LEN_W  (LEN_W)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .len     (len_s),
    .din     (cfg_data),
    .shift   (shift_s),
    .ser_bit (bit_s),
    .last    (last_s)
  );

  // State and word counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      word_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      word_cnt_r <= word_cnt_s;
    end
  end

  // Next-state logic and shift register control.
  always_comb begin
    state_s    = state_r;
    word_cnt_s = word_cnt_r;
    load_s     = 1'b0;
    shift_s    = 1'b0;
    len_s      = FULL_LEN;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s    = LOAD;
          word_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // An abort coinciding with the handshake swallows the word.
        if (abort) begin
          state_s = IDLE;
        end else if (cfg_valid) begin
          load_s  = 1'b1;
          len_s   = final_word_s ? LAST_LEN : FULL_LEN;
          state_s = SHIFT;
        end else begin
          state_s = LOAD;
        end
      end
      SHIFT: begin
        shift_s = 1'b1;
        if (abort) begin
          state_s = IDLE;
        end else if (last_s) begin
          if (final_word_s) begin
            state_s = COMMIT;
          end else begin
            word_cnt_s = word_cnt_r + WCW'(1);
            state_s    = LOAD;
          end
        end else begin
          state_s = SHIFT;
        end
      end
      COMMIT: begin
        // The set pulse of this cycle stands; only the done pulse is dropped.
        if (abort) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state register and shift register only.
  always_comb begin
    cfg_ready       = 1'b0;
    chain_shift_en  = 1'b0;
    chain_shift_bit = 1'b0;
    chain_set       = 1'b0;
    done            = 1'b0;
    busy            = (state_r != IDLE);
    case (state_r)
      LOAD: begin
        cfg_ready = 1'b1;
      end
      SHIFT: begin
        chain_shift_en  = 1'b1;
        chain_shift_bit = bit_s;
      end
      COMMIT: begin
        chain_set = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = (state_r != IDLE);
      end
    endcase
  end

endmodule

// File: tb/tb_slicel_config_loader.sv
// Self-checking bench for slicel_config_loader: table-driven sessions,
// randomized sessions against a bit-stream model, and edge-parameter instances.
module tb_slicel_config_loader;

  localparam int CFG    = 80;
  localparam int WW     = 32;
  localparam int NW     = (CFG + WW - 1) / WW;
  localparam int MINLEN = 1 + NW + CFG + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready, chain_shift_en, chain_shift_bit, chain_set, busy, done;

  logic        e_start, e_abort, e_valid;
  logic [31:0] e_data;
  logic        a_ready, a_en, a_bit, a_set, a_busy, a_done;
  logic        b_ready, b_en, b_bit, b_set, b_busy, b_done;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic got_q[$];
  int   set_cnt;
  int   done_cnt;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    int          stall;
    int          mode;       // 0 normal, 1 abort in word-2 shift, 2 abort in commit, 3 reset in commit
    int          abort_bit;
    int          exp_len;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  // Free-running cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  slicel_config_loader #(.CFG_BITS(CFG), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .chain_shift_en(chain_shift_en), .chain_shift_bit(chain_shift_bit),
    .chain_set(chain_set), .busy(busy), .done(done)
  );

  slicel_config_loader #(.CFG_BITS(32), .WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .start(e_start), .abort(e_abort),
    .cfg_valid(e_valid), .cfg_data(e_data), .cfg_ready(a_ready),
    .chain_shift_en(a_en), .chain_shift_bit(a_bit),
    .chain_set(a_set), .busy(a_busy), .done(a_done)
  );

  slicel_config_loader #(.CFG_BITS(1), .WORD_W(32)) dut1 (
    .clk(clk), .rst(rst), .start(e_start), .abort(e_abort),
    .cfg_valid(e_valid), .cfg_data(e_data), .cfg_ready(b_ready),
    .chain_shift_en(b_en), .chain_shift_bit(b_bit),
    .chain_set(b_set), .busy(b_busy), .done(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_session(input vec_t v);
    logic [31:0] w[3];
    logic        exp_q[$];
    int          k, stall_left, nsh, len, t0, mism;
    bit          finished;
    w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
    got_q.delete();
    set_cnt = 0; done_cnt = 0;
    k = 0; stall_left = v.stall; nsh = 0; len = -1; finished = 0;
    @(negedge clk);
    start = 1'b1; cfg_valid = 1'b0; t0 = cyc;
    for (int n = 0; n < 400 && !finished; n++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (chain_shift_en) begin got_q.push_back(chain_shift_bit); nsh++; end
      if (chain_set) set_cnt++;
      if (done) begin
        done_cnt++; len = cyc - t0 + 1; finished = 1;
      end else if (v.mode == 1 && chain_shift_en && nsh == WW + 1 + v.abort_bit) begin
        abort = 1'b1; finished = 1;
      end else if (v.mode == 2 && chain_set) begin
        abort = 1'b1; finished = 1;
      end else if (v.mode == 3 && chain_set) begin
        rst = 1'b1; finished = 1;
      end else begin
        if (k == 1 && stall_left > 0 && cfg_ready) begin
          cfg_valid = 1'b0; stall_left--;
          check("stall_no_shift", {63'd0, chain_shift_en}, 64'd0);
        end else begin
          cfg_valid = 1'b1;
          cfg_data  = (k < 3) ? w[k] : $urandom;
          if (cfg_ready) k++;
          // A start request mid-session must be ignored.
          if (chain_shift_en && ($urandom_range(0, 7) == 0)) start = 1'b1;
        end
      end
    end
    if (!finished) check("session_timeout", 64'd0, 64'd1);
    case (v.mode)
      0: begin
        for (int i = 0; i < CFG; i++) begin
          logic [31:0] wd;
          wd = w[i / WW];
          exp_q.push_back(wd[i % WW]);
        end
        mism = 0;
        for (int i = 0; i < CFG && i < got_q.size(); i++)
          if (got_q[i] !== exp_q[i]) mism++;
        check("session_len", 64'(len), 64'(v.exp_len));
        check("stream_len", 64'(got_q.size()), 64'(CFG));
        check("stream_bits", 64'(mism), 64'd0);
        check("set_pulses", 64'(set_cnt), 64'd1);
        @(negedge clk);
        start = 1'b0; cfg_valid = 1'b0;
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
      end
      1, 2: begin
        @(negedge clk);
        abort = 1'b0; cfg_valid = 1'b0; start = 1'b0;
        check("abort_idle", {60'd0, busy, cfg_ready, chain_shift_en, done}, 64'd0);
        for (int i = 0; i < 4; i++) begin
          if (chain_set) set_cnt++;
          if (done) done_cnt++;
          @(negedge clk);
        end
        check("abort_set_cnt", 64'(set_cnt), (v.mode == 2) ? 64'd1 : 64'd0);
        check("abort_done_cnt", 64'(done_cnt), 64'd0);
      end
      3: begin
        @(negedge clk);
        rst = 1'b0; cfg_valid = 1'b0; start = 1'b0;
        check("rst_in_commit",
              {58'd0, cfg_ready, chain_shift_en, chain_shift_bit, chain_set, busy, done}, 64'd0);
        @(negedge clk);
        check("rst_no_done", {62'd0, done, busy}, 64'd0);
      end
      default: check("bad_mode", 64'd0, 64'd1);
    endcase
  endtask

  initial begin
    logic qa[$];
    logic qb[$];
    int   la, lb, t0, sa, sb, ones, mism;
    vec_t rv;

    tbl[0] = '{32'hDEADBEEF, 32'h12345678, 32'h0000A5A5, 0, 0, 0, MINLEN};
    tbl[1] = '{32'h01234567, 32'h89ABCDEF, 32'hFFFF0000, 0, 0, 0, MINLEN};
    tbl[2] = '{32'hDEADBEEF, 32'h12345678, 32'h0000A5A5, 5, 0, 0, MINLEN + 5};
    tbl[3] = '{32'hCAFEF00D, 32'h0F0F0F0F, 32'h00005A5A, 0, 1, 10, -1};
    tbl[4] = '{32'hDEADBEEF, 32'h12345678, 32'h0000A5A5, 0, 0, 0, MINLEN};
    tbl[5] = '{32'h13579BDF, 32'h2468ACE0, 32'h0000FFFF, 0, 2, 0, -1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 32'd0;
    e_start = 1'b0; e_abort = 1'b0; e_valid = 1'b0; e_data = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {58'd0, cfg_ready, chain_shift_en, chain_shift_bit, chain_set, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs",
          {58'd0, cfg_ready, chain_shift_en, chain_shift_bit, chain_set, busy, done}, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_session(tbl[i]);
      if (i == 1) begin
        ones = 0;
        for (int b = 64; b < got_q.size(); b++) if (got_q[b] !== 1'b0) ones++;
        check("final_word_upper_zero", 64'(ones), 64'd0);
      end
    end

    // Reset landing on the commit cycle.
    rv = tbl[0]; rv.mode = 3; rv.exp_len = -1;
    run_session(rv);
    // A clean session after the reset.
    run_session(tbl[0]);

    for (int r = 0; r < 6; r++) begin
      rv.w0 = $urandom; rv.w1 = $urandom; rv.w2 = $urandom;
      rv.stall = $urandom_range(0, 4); rv.mode = 0; rv.abort_bit = 0;
      rv.exp_len = MINLEN + rv.stall;
      run_session(rv);
    end

    // Edge parameters: one full word (32/32) and a single-bit chain (1/32).
    @(negedge clk);
    e_start = 1'b1; e_valid = 1'b0; e_data = $urandom; t0 = cyc;
    la = -1; lb = -1; sa = 0; sb = 0;
    for (int n = 0; n < 100 && (la < 0 || lb < 0); n++) begin
      @(negedge clk);
      e_start = 1'b0; e_valid = 1'b1;
      if (a_en) qa.push_back(a_bit);
      if (b_en) qb.push_back(b_bit);
      if (a_set) sa++;
      if (b_set) sb++;
      if (a_done && la < 0) la = cyc - t0 + 1;
      if (b_done && lb < 0) lb = cyc - t0 + 1;
    end
    e_valid = 1'b0;
    mism = 0;
    for (int i = 0; i < 32 && i < qa.size(); i++) if (qa[i] !== e_data[i]) mism++;
    check("w32_len", 64'(la), 64'(1 + 1 + 32 + 2));
    check("w32_shifts", 64'(qa.size()), 64'd32);
    check("w32_bits", 64'(mism), 64'd0);
    check("w32_set", 64'(sa), 64'd1);
    check("b1_len", 64'(lb), 64'(1 + 1 + 1 + 2));
    check("b1_shifts", 64'(qb.size()), 64'd1);
    if (qb.size() > 0) check("b1_bit", {63'd0, qb[0]}, {63'd0, e_data[0]});
    else check("b1_bit_missing", 64'd0, 64'd1);
    check("b1_set", 64'(sb), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
